// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out an 11-bit frame
// on device clock edges, then check the device ACK. Pads are driven open-drain via *_oe.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned CNT_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INHIBIT = 3'd1;
    localparam logic [2:0] ST_RTS     = 3'd2;
    localparam logic [2:0] ST_SHIFT   = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;
    localparam logic [2:0] ST_WAITREL = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;
    localparam logic [2:0] ST_FAIL    = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [9:0]       frame_q, frame_d;
    logic             dat_oe_q, dat_oe_d;
    logic [2:0]       clk_sync_q;
    logic [1:0]       dat_sync_q;

    logic clk_synced;
    logic dat_synced;
    logic clk_fall;
    logic in_wait;
    logic tmo_expired;

    assign clk_synced  = clk_sync_q[1];
    assign dat_synced  = dat_sync_q[1];
    assign clk_fall    = clk_sync_q[2] & ~clk_sync_q[1];
    assign in_wait     = (state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_WAITREL);
    assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        bitcnt_d = bitcnt_q;
        frame_d  = frame_q;
        dat_oe_d = dat_oe_q;

        if (in_wait) begin
            if (clk_fall) begin
                tmo_d = '0;
            end else if (!tmo_expired) begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                dat_oe_d = 1'b0;
                if (tx_start) begin
                    frame_d = {1'b1, ~^tx_data, tx_data};
                    cnt_d   = '0;
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    state_d = ST_RTS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RTS: begin
                dat_oe_d = 1'b1;
                bitcnt_d = '0;
                tmo_d    = '0;
                state_d  = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Each device falling edge presents the next frame bit; the 10th is the stop bit.
                if (clk_fall) begin
                    dat_oe_d = ~frame_q[bitcnt_q];
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    state_d = dat_synced ? ST_FAIL : ST_WAITREL;
                end
            end
            ST_WAITREL: begin
                if (clk_synced && dat_synced) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                dat_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stalled device wins over any edge arriving in the same cycle.
        if (in_wait && tmo_expired) begin
            state_d  = ST_FAIL;
            dat_oe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            bitcnt_q   <= '0;
            frame_q    <= '0;
            dat_oe_q   <= 1'b0;
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            bitcnt_q   <= bitcnt_d;
            frame_q    <= frame_d;
            dat_oe_q   <= dat_oe_d;
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
        end
    end

    assign tx_busy    = (state_q != ST_IDLE);
    assign tx_done    = (state_q == ST_DONE);
    assign tx_error   = (state_q == ST_FAIL);
    assign ps2_clk_oe = (state_q == ST_INHIBIT) || (state_q == ST_RTS);
    assign ps2_dat_oe = (state_q == ST_RTS) || ((state_q == ST_SHIFT) && dat_oe_q);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model drives the clock and captures frames; a
// scoreboard monitor pops the expected outcome on every tx_done/tx_error pulse.
module tb_ps2_host_tx;

    localparam int unsigned INH = 10;
    localparam int unsigned TMO = 200;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       ps2_clk_in, ps2_dat_in;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    // Open-drain bus: either side can pull low.
    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        bit         chk;
        logic [7:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] cap_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Wire order: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            ones += int'(d[i]);
            f[i+1] = d[i];
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!resetn && (tx_done || tx_error)) begin
            exp_t e;
            logic [10:0] cap;
            check("done_error_exclusive", 32'(tx_done & tx_error), 0);
            if (exp_q.size() == 0) begin
                bound_fail("unexpected_pulse");
            end else begin
                e = exp_q.pop_front();
                check("outcome_err_done", {30'd0, tx_error, tx_done},
                      e.is_err ? 32'd2 : 32'd1);
                if (e.chk) begin
                    if (cap_q.size() == 0) begin
                        bound_fail("no_captured_frame");
                    end else begin
                        cap = cap_q.pop_front();
                        check("frame_bits", 32'(cap), 32'(ref_frame(e.data)));
                    end
                end
            end
            @(negedge clk);
            check("idle_after_pulse", {27'd0, tx_done, tx_error, tx_busy, ps2_clk_oe, ps2_dat_oe},
                  0);
        end
    end

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Follows inhibit, RTS and entry into SHIFT; returns in the first SHIFT cycle.
    task automatic check_inhibit();
        int n;
        check("busy_after_start", 32'(tx_busy), 1);
        n = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n < 100) begin
            n++;
            tick();
        end
        check("inhibit_cycles", n, INH);
        check("rts_both_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 3);
        tick();
        check("shift_entry_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 1);
    endtask

    task automatic device_frame(input bit do_ack, input bit inject, input int reset_at,
                                output bit aborted);
        logic [10:0] cap;
        int t;
        aborted = 1'b0;
        cap = '0;
        t = 0;
        while (!(ps2_clk_in && !ps2_dat_in) && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) begin
            bound_fail("rts_wait");
            return;
        end
        repeat (5) tick();
        for (int i = 0; i < 11; i++) begin
            cap[i] = ps2_dat_in;
            if (i == 10) break;
            dev_clk = 1'b0;
            for (int c = 0; c < 10; c++) begin
                if (inject && i == 2 && c == 3) begin
                    tx_data  = 8'h55;
                    tx_start = 1'b1;
                end else begin
                    tx_start = 1'b0;
                end
                if (reset_at == i + 1 && c == 5) begin
                    resetn = 1'b1;
                    #1;
                    check("reset_midframe", {29'd0, tx_busy, ps2_clk_oe, ps2_dat_oe}, 0);
                    dev_clk = 1'b1;
                    dev_dat = 1'b1;
                    repeat (2) tick();
                    resetn = 1'b0;
                    tick();
                    aborted = 1'b1;
                    return;
                end
                tick();
            end
            dev_clk = 1'b1;
            repeat (10) tick();
        end
        cap_q.push_back(cap);
        if (do_ack) dev_dat = 1'b0;
        repeat (5) tick();
        dev_clk = 1'b0;
        repeat (10) tick();
        dev_clk = 1'b1;
        repeat (5) tick();
        dev_dat = 1'b1;
        repeat (5) tick();
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (tx_busy && t < 300) begin
            tick();
            t++;
        end
        if (t >= 300) bound_fail("wait_idle");
        repeat (3) tick();
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input bit inject,
                             input int reset_at);
        bit aborted;
        if (reset_at < 0) exp_q.push_back('{is_err: !ack, chk: 1'b1, data: d});
        start_tx(d);
        check_inhibit();
        device_frame(ack, inject, reset_at, aborted);
        if (!aborted) wait_idle();
    endtask

    initial begin
        int c;
        repeat (3) tick();
        check("in_reset_outputs",
              {27'd0, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 0);
        resetn = 1'b0;
        repeat (2) tick();
        check("after_reset_outputs",
              {27'd0, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 0);

        run_frame(8'hED, 1'b1, 1'b0, -1);
        run_frame(8'h00, 1'b1, 1'b0, -1);
        run_frame(8'h01, 1'b1, 1'b0, -1);
        run_frame(8'hA7, 1'b0, 1'b0, -1);

        // Device never clocks: error must come exactly TMO cycles after SHIFT entry.
        exp_q.push_back('{is_err: 1'b1, chk: 1'b0, data: 8'h3A});
        start_tx(8'h3A);
        check_inhibit();
        c = 0;
        while (!tx_error && c < 1000) begin
            tick();
            c++;
        end
        check("timeout_cycles", c, TMO);
        repeat (5) tick();

        run_frame(8'hF4, 1'b1, 1'b1, -1);
        repeat (300) tick();
        check("start_while_busy_ignored", 32'(tx_busy), 0);

        run_frame(8'h3C, 1'b1, 1'b0, 4);
        run_frame(8'hFF, 1'b1, 1'b0, -1);

        for (int k = 0; k < 16; k++) begin
            run_frame(8'($urandom), ($urandom_range(0, 3) != 0), 1'b0, -1);
            repeat ($urandom_range(1, 20)) tick();
        end

        repeat (20) tick();
        check("pending_expected", exp_q.size(), 0);
        check("pending_captures", cap_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
